// File: rtl/sopc_imem_if.sv
// rtl/sopc_imem_if.sv - fetch and program-load bus between CPU and sopc_imem
// Purpose: bundles the CPU fetch handshake, program-load write port and fetch counter.
// Signals:
//   cpu_req/cpu_addr/cpu_flush      fetch request, byte address, cancel (master -> slave)
//   cpu_stall/cpu_rdata/cpu_rvalid  stall, fetched word, data-valid pulse (slave -> master)
//   addr_err                        out-of-range pulse alongside cpu_rvalid (slave -> master)
//   prog_we/prog_addr/prog_wdata    program-load write strobe, byte address, data (master -> slave)
//   fetch_cnt                       completed fetches, saturating (slave -> master)
interface sopc_imem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_flush;
  logic              cpu_stall;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;
  logic              addr_err;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_wdata;
  logic [31:0]       fetch_cnt;

  modport master (
    output cpu_req, cpu_addr, cpu_flush, prog_we, prog_addr, prog_wdata,
    input  cpu_stall, cpu_rdata, cpu_rvalid, addr_err, fetch_cnt
  );

  modport slave (
    input  cpu_req, cpu_addr, cpu_flush, prog_we, prog_addr, prog_wdata,
    output cpu_stall, cpu_rdata, cpu_rvalid, addr_err, fetch_cnt
  );
endinterface

// File: rtl/sopc_imem.sv
// rtl/sopc_imem.sv - instruction memory with wait states, flush, program load and fetch counter
// Purpose: registered-read instruction store for the SOPC fetch stage.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (storage is not cleared)
//   bus    sopc_imem_if.slave: fetch handshake, program-load port, fetch counter
module sopc_imem #(
  parameter int    ADDR_W      = 32,
  parameter int    DATA_W      = 32,
  parameter int    DEPTH       = 1024,
  parameter int    WAIT_CYCLES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic       clk,
  input  logic       rst_n,
  sopc_imem_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {IDLE, WAIT} state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t           state, state_n;
  logic [3:0]       cnt, cnt_n;
  logic [IDX_W-1:0] idx_q;
  logic             oor_q;
  logic             accept, do_read;

  logic [IDX_W-1:0] cur_idx, rd_idx, wr_idx;
  logic             cur_oor, rd_oor, wr_oor;

  // Word-aligned addressing: the two byte-offset bits carry no information.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.cpu_addr[1:0], bus.prog_addr[1:0]};

  assign cur_idx = bus.cpu_addr[IDX_W+1:2];
  assign cur_oor = |bus.cpu_addr[ADDR_W-1:IDX_W+2];
  assign wr_idx  = bus.prog_addr[IDX_W+1:2];
  assign wr_oor  = |bus.prog_addr[ADDR_W-1:IDX_W+2];

  // With no wait states the read happens on the accept edge from the live
  // address; otherwise it uses the address captured when the fetch was accepted.
  assign rd_idx = (state == IDLE) ? cur_idx : idx_q;
  assign rd_oor = (state == IDLE) ? cur_oor : oor_q;

  // A request coinciding with a flush is refused.
  assign accept = bus.cpu_req & ~bus.cpu_stall & ~bus.cpu_flush;

  // Storage survives reset; out-of-range program writes are dropped.
  always_ff @(posedge clk) begin
    if (bus.prog_we && !wr_oor) begin
      mem[wr_idx] <= bus.prog_wdata;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    do_read = 1'b0;
    if (bus.cpu_flush) begin
      state_n = IDLE;
      cnt_n   = 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (WAIT_CYCLES == 0) begin
              do_read = 1'b1;
            end else begin
              state_n = WAIT;
              cnt_n   = 4'(WAIT_CYCLES);
            end
          end
        end
        WAIT: begin
          // The edge on which the counter would reach zero performs the read.
          if (cnt <= 4'd1) begin
            do_read = 1'b1;
            state_n = IDLE;
            cnt_n   = 4'd0;
          end else begin
            cnt_n = cnt - 4'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      idx_q          <= '0;
      oor_q          <= 1'b0;
      bus.cpu_stall  <= 1'b0;
      bus.cpu_rdata  <= '0;
      bus.cpu_rvalid <= 1'b0;
      bus.addr_err   <= 1'b0;
      bus.fetch_cnt  <= 32'd0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      bus.cpu_stall  <= (state_n == WAIT);
      bus.cpu_rvalid <= do_read;
      bus.addr_err   <= do_read & rd_oor;
      if (accept) begin
        idx_q <= cur_idx;
        oor_q <= cur_oor;
      end
      // Nonblocking read of mem sees the pre-edge contents: read-before-write.
      if (do_read) begin
        bus.cpu_rdata <= rd_oor ? '0 : mem[rd_idx];
        if (bus.fetch_cnt != 32'hFFFF_FFFF) begin
          bus.fetch_cnt <= bus.fetch_cnt + 32'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_sopc_imem.sv
// tb/tb_sopc_imem.sv - self-checking bench for sopc_imem at 0, 2 and 3 wait states
module tb_sopc_imem;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int wv [3] = '{0, 2, 3};

  logic        req   [3];
  logic [31:0] addr  [3];
  logic        flush [3];
  logic        pwe   [3];
  logic [31:0] paddr [3];
  logic [31:0] pwdata[3];

  logic        stall_o [3];
  logic [31:0] rdata_o [3];
  logic        rvalid_o[3];
  logic        err_o   [3];
  logic [31:0] cnt_o   [3];

  for (genvar g = 0; g < 3; g++) begin : u
    sopc_imem_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    sopc_imem #(
      .ADDR_W(32), .DATA_W(32), .DEPTH(1024),
      .WAIT_CYCLES((g == 0) ? 0 : (g == 1) ? 2 : 3), .INIT_FILE("")
    ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus.slave)
    );
    assign bus.cpu_req    = req[g];
    assign bus.cpu_addr   = addr[g];
    assign bus.cpu_flush  = flush[g];
    assign bus.prog_we    = pwe[g];
    assign bus.prog_addr  = paddr[g];
    assign bus.prog_wdata = pwdata[g];
    assign stall_o[g]  = bus.cpu_stall;
    assign rdata_o[g]  = bus.cpu_rdata;
    assign rvalid_o[g] = bus.cpu_rvalid;
    assign err_o[g]    = bus.addr_err;
    assign cnt_o[g]    = bus.fetch_cnt;
  end

  // Reference model: a fetch accepted at cycle c completes at cycle c+W,
  // reading the model store as it stands before that edge's write.
  logic [31:0] mm   [3][16];
  bit          pend [3];
  int          due  [3];
  logic [31:0] fa   [3];
  bit          e_rv [3];
  logic [31:0] e_rd [3];
  bit          e_err[3];
  logic [31:0] e_cnt[3];
  int          cyc = 0;

  int nerr = 0;
  int nchk = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      pend[i] = 0; e_rv[i] = 0; e_rd[i] = 0; e_err[i] = 0; e_cnt[i] = 0;
    end
  endtask

  task automatic tick();
    for (int i = 0; i < 3; i++) begin
      bit acc;
      e_rv[i]  = 0;
      e_err[i] = 0;
      if (!rst_n) begin
        pend[i] = 0; e_rd[i] = 0; e_cnt[i] = 0;
      end else begin
        acc = req[i] && !flush[i] && !pend[i];
        if (flush[i]) pend[i] = 0;
        if (acc) begin
          pend[i] = 1; due[i] = cyc + wv[i]; fa[i] = addr[i];
        end
        if (pend[i] && due[i] == cyc) begin
          pend[i]  = 0;
          e_rv[i]  = 1;
          e_err[i] = (fa[i] >= 32'h1000);
          e_rd[i]  = e_err[i] ? 32'd0 : mm[i][fa[i] >> 2];
          if (e_cnt[i] != 32'hFFFF_FFFF) e_cnt[i] = e_cnt[i] + 1;
        end
        if (pwe[i] && paddr[i] < 32'h1000) mm[i][paddr[i] >> 2] = pwdata[i];
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("w%0d_rvalid@%0d", wv[i], cyc), 64'(rvalid_o[i]), 64'(e_rv[i]));
      chk($sformatf("w%0d_stall@%0d", wv[i], cyc), 64'(stall_o[i]), 64'(pend[i]));
      chk($sformatf("w%0d_rdata@%0d", wv[i], cyc), 64'(rdata_o[i]), 64'(e_rd[i]));
      chk($sformatf("w%0d_err@%0d", wv[i], cyc), 64'(err_o[i]), 64'(e_err[i]));
      chk($sformatf("w%0d_cnt@%0d", wv[i], cyc), 64'(cnt_o[i]), 64'(e_cnt[i]));
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      req[i] = 0; addr[i] = 0; flush[i] = 0; pwe[i] = 0; paddr[i] = 0; pwdata[i] = 0;
    end
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_stall", 64'(stall_o[i]), 64'd0);
      chk("reset_rvalid", 64'(rvalid_o[i]), 64'd0);
      chk("reset_rdata", 64'(rdata_o[i]), 64'd0);
      chk("reset_err", 64'(err_o[i]), 64'd0);
      chk("reset_cnt", 64'(cnt_o[i]), 64'd0);
    end

    // Program words 0..15; words 0..3 are 0x11,0x22,0x33,0x44.
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 3; i++) begin
        pwe[i] = 1; paddr[i] = 32'(k * 4);
        pwdata[i] = (k < 4) ? 32'(17 * (k + 1)) : $urandom;
      end
      tick();
    end
    for (int i = 0; i < 3; i++) pwe[i] = 0;

    // Back-to-back fetches with no wait states.
    req[0] = 1;
    for (int j = 0; j < 4; j++) begin
      addr[0] = 32'(j * 4);
      tick();
      chk("b2b_rvalid", 64'(rvalid_o[0]), 64'd1);
      chk("b2b_rdata", 64'(rdata_o[0]), 64'(17 * (j + 1)));
      chk("b2b_stall", 64'(stall_o[0]), 64'd0);
    end
    req[0] = 0;
    tick();
    chk("b2b_cnt", 64'(cnt_o[0]), 64'd4);

    // Two wait states with request held.
    req[1] = 1; addr[1] = 32'd4;
    tick();
    chk("w2_stall1", 64'(stall_o[1]), 64'd1);
    tick();
    chk("w2_stall2", 64'(stall_o[1]), 64'd1);
    chk("w2_norv", 64'(rvalid_o[1]), 64'd0);
    tick();
    chk("w2_rvalid", 64'(rvalid_o[1]), 64'd1);
    chk("w2_rdata", 64'(rdata_o[1]), 64'h22);
    chk("w2_stall_low", 64'(stall_o[1]), 64'd0);
    tick();
    chk("w2_reaccept", 64'(stall_o[1]), 64'd1);
    req[1] = 0;
    tick();
    tick();
    chk("w2_cnt", 64'(cnt_o[1]), 64'd2);

    // Out-of-range fetch.
    req[0] = 1; addr[0] = 32'h1000;
    tick();
    chk("oor_rvalid", 64'(rvalid_o[0]), 64'd1);
    chk("oor_err", 64'(err_o[0]), 64'd1);
    chk("oor_rdata", 64'(rdata_o[0]), 64'd0);
    chk("oor_cnt", 64'(cnt_o[0]), 64'd5);
    req[0] = 0;
    tick();

    // Flush one cycle after accept with three wait states.
    req[2] = 1; addr[2] = 32'd0;
    tick();
    req[2] = 0; flush[2] = 1;
    tick();
    chk("flush_stall", 64'(stall_o[2]), 64'd0);
    flush[2] = 0;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("flush_norv", 64'(rvalid_o[2]), 64'd0);
    end
    chk("flush_cnt", 64'(cnt_o[2]), 64'd0);

    // Read-before-write on the same word, then refetch.
    req[0] = 1; addr[0] = 32'd8; pwe[0] = 1; paddr[0] = 32'd8; pwdata[0] = 32'hDEAD;
    tick();
    chk("rbw_old", 64'(rdata_o[0]), 64'h33);
    pwe[0] = 0;
    tick();
    chk("rbw_new", 64'(rdata_o[0]), 64'hDEAD);
    req[0] = 0;
    tick();

    // Asynchronous reset in the middle of a wait.
    req[1] = 1; addr[1] = 32'd0;
    tick();
    req[1] = 0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      chk("arst_stall", 64'(stall_o[i]), 64'd0);
      chk("arst_rvalid", 64'(rvalid_o[i]), 64'd0);
      chk("arst_rdata", 64'(rdata_o[i]), 64'd0);
      chk("arst_cnt", 64'(cnt_o[i]), 64'd0);
    end
    tick();
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) tick();
    req[1] = 1;
    tick();
    req[1] = 0;
    tick();
    tick();
    chk("arst_retain", 64'(rdata_o[1]), 64'h11);

    // Randomized traffic on all three instances.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) begin
        req[i]   = ($urandom_range(0, 9) < 7);
        flush[i] = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 9) == 0)
          addr[i] = ($urandom_range(0, 1) == 0) ? 32'h1000 + 32'($urandom_range(0, 255) * 4) : 32'h8000_0004;
        else
          addr[i] = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
        pwe[i]    = ($urandom_range(0, 4) == 0);
        paddr[i]  = ($urandom_range(0, 7) == 0) ? 32'h2000 : 32'($urandom_range(0, 15) * 4);
        pwdata[i] = $urandom;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
